// File: rtl/temporal_buffer_pp.sv
// -----------------------------------------------------------------------------
// temporal_buffer_pp
//
// Double-banked (ping-pong) candidate-clause buffer sitting between the
// clause-evaluation pipeline and the heuristic selector.
//
// The write side fills one bank. Each write stores one clause per flip row and
// adds a saturating break count to that row. A commit hands the filled bank to
// the read side. The read side exposes the committed bank's per-row valid flags
// and break counts, and serves one clause per request with a 1-cycle latency.
// A release frees the read bank, clearing its valid flags and counts, so the
// writer can reuse it. The two banks alternate, so generation k+1 can be filled
// while generation k is being selected from.
//
// Ports
//   clk                      rising-edge clock
//   reset                    asynchronous active-low reset
//   flush_i                  synchronous clear of both banks and all pointers
//   wr_valid_i / wr_ready_o  write request / write bank free
//   write_index_i            flip row to write
//   flipped_literal_i        literal 0 of the clause
//   clause_table_literals_i  literals 1..NSAT-1 (packed slot k -> literal k+1)
//   break_count_i            added (saturating) to the row's break count
//   wr_commit_i              close the write bank and hand it to the reader
//   rd_avail_o               a committed bank is readable
//   row_valid_o              per-row written flags of the read bank
//   break_counts_o           per-row break counts of the read bank
//   rd_req_i / read_index_i  clause read request / selected row
//   clause_o                 selected clause, held until the next read
//   clause_valid_o           one-cycle pulse qualifying clause_o
//   miss_o                   selected row unwritten or out of range
//   rd_release_i             free the read bank
// -----------------------------------------------------------------------------
module temporal_buffer_pp #(
  parameter int NSAT                  = 3,
  parameter int LITERAL_ADDRESS_WIDTH = 11,
  parameter int NSAT_BITS             = 2,
  parameter int BREAK_W               = 8
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           flush_i,
  input  logic                                           wr_valid_i,
  output logic                                           wr_ready_o,
  input  logic [NSAT_BITS-1:0]                           write_index_i,
  input  logic [LITERAL_ADDRESS_WIDTH:0]                 flipped_literal_i,
  input  logic [(NSAT-1)*(LITERAL_ADDRESS_WIDTH+1)-1:0]  clause_table_literals_i,
  input  logic [BREAK_W-1:0]                             break_count_i,
  input  logic                                           wr_commit_i,
  output logic                                           rd_avail_o,
  output logic [NSAT-1:0]                                row_valid_o,
  output logic [NSAT*BREAK_W-1:0]                        break_counts_o,
  input  logic                                           rd_req_i,
  input  logic [NSAT_BITS-1:0]                           read_index_i,
  output logic [NSAT*(LITERAL_ADDRESS_WIDTH+1)-1:0]      clause_o,
  output logic                                           clause_valid_o,
  output logic                                           miss_o,
  input  logic                                           rd_release_i
);

  localparam int L  = LITERAL_ADDRESS_WIDTH + 1;
  localparam int CW = NSAT * L;

  // Bank storage. Literals carry no reset: a row's literals are only ever
  // observed through its valid bit, which is reset.
  logic [CW-1:0]      r_lits  [2][NSAT];
  logic [NSAT-1:0]    r_valid [2];
  logic [BREAK_W-1:0] r_count [2][NSAT];

  logic       r_wp;
  logic       r_rp;
  logic [1:0] r_full;

  logic [CW-1:0] r_clause;
  logic          r_clause_valid;
  logic          r_miss;

  logic               w_wr_ready;
  logic               w_rd_avail;
  logic               w_wr_fire;
  logic               w_commit;
  logic               w_release;
  logic               w_rd_fire;
  logic [NSAT-1:0]    w_wr_sel;
  logic [NSAT-1:0]    w_rd_sel;
  logic [BREAK_W-1:0] w_cur_count;
  logic [BREAK_W:0]   w_sum;
  logic [BREAK_W-1:0] w_new_count;
  logic [CW-1:0]      w_rd_clause;
  logic               w_rd_hit;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign w_wr_ready = ~r_full[r_wp];
  assign w_rd_avail = r_full[r_rp];

  // A write only lands if the index decodes to a real row; an out-of-range
  // index leaves w_wr_sel all-zero and the write is dropped.
  assign w_wr_fire = wr_valid_i & w_wr_ready & (|w_wr_sel);
  assign w_commit  = wr_commit_i & w_wr_ready;
  assign w_release = rd_release_i & w_rd_avail;
  assign w_rd_fire = rd_req_i & w_rd_avail;

  // Row decoders. Comparing against each legal row avoids ever indexing the
  // arrays with an out-of-range value.
  always_comb begin
    for (int r = 0; r < NSAT; r++) begin
      w_wr_sel[r] = (write_index_i == NSAT_BITS'(r));
      w_rd_sel[r] = (read_index_i  == NSAT_BITS'(r));
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating break-count update for the row being written
  // ---------------------------------------------------------------------------
  // NOTE: every variable in an always_comb gets a default before any branch,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    w_cur_count = '0;
    for (int r = 0; r < NSAT; r++) begin
      if (w_wr_sel[r]) w_cur_count = r_count[r_wp][r];
    end
  end

  assign w_sum       = {1'b0, w_cur_count} + {1'b0, break_count_i};
  assign w_new_count = w_sum[BREAK_W] ? {BREAK_W{1'b1}} : w_sum[BREAK_W-1:0];

  // ---------------------------------------------------------------------------
  // Literal storage (no reset, no flush)
  // ---------------------------------------------------------------------------
  // NOTE: large data arrays are left out of reset; only the control state that
  // qualifies them (valid bits, counts, pointers) is reset.
  always_ff @(posedge clk) begin
    if (!flush_i && w_wr_fire) begin
      for (int r = 0; r < NSAT; r++) begin
        if (w_wr_sel[r]) r_lits[r_wp][r] <= {clause_table_literals_i, flipped_literal_i};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bank control: valid bits, counts, pointers, full flags.
  // Commit requires full[wp]==0 and release requires full[rp]==1, so whenever
  // both fire they address different banks and never collide. For the same
  // reason a write never targets the bank being released.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the values from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp   <= 1'b0;
      r_rp   <= 1'b0;
      r_full <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        r_valid[b] <= '0;
        for (int r = 0; r < NSAT; r++) r_count[b][r] <= '0;
      end
    end else if (flush_i) begin
      r_wp   <= 1'b0;
      r_rp   <= 1'b0;
      r_full <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        r_valid[b] <= '0;
        for (int r = 0; r < NSAT; r++) r_count[b][r] <= '0;
      end
    end else begin
      if (w_release) begin
        r_full[r_rp]  <= 1'b0;
        r_valid[r_rp] <= '0;
        for (int r = 0; r < NSAT; r++) r_count[r_rp][r] <= '0;
        r_rp <= ~r_rp;
      end

      // A write in the commit cycle still lands in the committing bank, since
      // r_wp here is the pre-swap value.
      if (w_wr_fire) begin
        for (int r = 0; r < NSAT; r++) begin
          if (w_wr_sel[r]) begin
            r_valid[r_wp][r] <= 1'b1;
            r_count[r_wp][r] <= w_new_count;
          end
        end
      end

      if (w_commit) begin
        r_full[r_wp] <= 1'b1;
        r_wp         <= ~r_wp;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Clause read path (1-cycle latency). The lookup uses the pre-edge contents,
  // so a read accepted together with a release returns pre-release data.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_clause = '0;
    w_rd_hit    = 1'b0;
    for (int r = 0; r < NSAT; r++) begin
      if (w_rd_sel[r] && r_valid[r_rp][r]) begin
        w_rd_clause = r_lits[r_rp][r];
        w_rd_hit    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clause       <= '0;
      r_clause_valid <= 1'b0;
      r_miss         <= 1'b0;
    end else if (flush_i) begin
      r_clause       <= '0;
      r_clause_valid <= 1'b0;
      r_miss         <= 1'b0;
    end else if (w_rd_fire) begin
      r_clause       <= w_rd_clause;
      r_clause_valid <= 1'b1;
      r_miss         <= ~w_rd_hit;
    end else begin
      // clause_o holds; only the qualifying pulses drop.
      r_clause_valid <= 1'b0;
      r_miss         <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wr_ready_o     = w_wr_ready;
  assign rd_avail_o     = w_rd_avail;
  assign clause_o       = r_clause;
  assign clause_valid_o = r_clause_valid;
  assign miss_o         = r_miss;

  // The read bank is only exposed once committed; otherwise the flags and
  // counts read as zero.
  always_comb begin
    row_valid_o    = '0;
    break_counts_o = '0;
    if (w_rd_avail) begin
      row_valid_o = r_valid[r_rp];
      for (int r = 0; r < NSAT; r++) begin
        break_counts_o[r*BREAK_W +: BREAK_W] = r_count[r_rp][r];
      end
    end
  end

endmodule

// File: tb/tb_temporal_buffer_pp.sv
// -----------------------------------------------------------------------------
// tb_temporal_buffer_pp
//
// Self-checking bench for temporal_buffer_pp (NSAT=3, L=12, BREAK_W=8).
// The reference model is a FIFO of committed generations (at most two) plus
// the generation currently being filled; a read looks at the oldest committed
// generation, a release drops it, a commit appends the current one.
// -----------------------------------------------------------------------------
module tb_temporal_buffer_pp;

  localparam int NSAT = 3;
  localparam int LAW  = 11;
  localparam int NB   = 2;
  localparam int BW   = 8;
  localparam int L    = LAW + 1;
  localparam int CW   = NSAT * L;

  typedef struct packed {
    logic [NSAT-1:0]          valid;
    logic [NSAT-1:0][BW-1:0]  count;
    logic [NSAT-1:0][CW-1:0]  lits;
  } gen_t;

  logic                   clk;
  logic                   reset;
  logic                   flush_i;
  logic                   wr_valid_i;
  logic                   wr_ready_o;
  logic [NB-1:0]          write_index_i;
  logic [L-1:0]           flipped_literal_i;
  logic [(NSAT-1)*L-1:0]  clause_table_literals_i;
  logic [BW-1:0]          break_count_i;
  logic                   wr_commit_i;
  logic                   rd_avail_o;
  logic [NSAT-1:0]        row_valid_o;
  logic [NSAT*BW-1:0]     break_counts_o;
  logic                   rd_req_i;
  logic [NB-1:0]          read_index_i;
  logic [CW-1:0]          clause_o;
  logic                   clause_valid_o;
  logic                   miss_o;
  logic                   rd_release_i;

  temporal_buffer_pp #(
    .NSAT(NSAT), .LITERAL_ADDRESS_WIDTH(LAW), .NSAT_BITS(NB), .BREAK_W(BW)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .flush_i                 (flush_i),
    .wr_valid_i              (wr_valid_i),
    .wr_ready_o              (wr_ready_o),
    .write_index_i           (write_index_i),
    .flipped_literal_i       (flipped_literal_i),
    .clause_table_literals_i (clause_table_literals_i),
    .break_count_i           (break_count_i),
    .wr_commit_i             (wr_commit_i),
    .rd_avail_o              (rd_avail_o),
    .row_valid_o             (row_valid_o),
    .break_counts_o          (break_counts_o),
    .rd_req_i                (rd_req_i),
    .read_index_i            (read_index_i),
    .clause_o                (clause_o),
    .clause_valid_o          (clause_valid_o),
    .miss_o                  (miss_o),
    .rd_release_i            (rd_release_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  gen_t         q[$];     // committed generations, oldest first
  gen_t         cur;      // generation being filled
  logic [CW-1:0] m_clause; // last clause returned

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cur      = '0;
    m_clause = '0;
  endtask

  task automatic idle_inputs();
    flush_i                 = 1'b0;
    wr_valid_i              = 1'b0;
    write_index_i           = '0;
    flipped_literal_i       = '0;
    clause_table_literals_i = '0;
    break_count_i           = '0;
    wr_commit_i             = 1'b0;
    rd_req_i                = 1'b0;
    read_index_i            = '0;
    rd_release_i            = 1'b0;
  endtask

  // One clock cycle: drive inputs, check the combinational view against the
  // model, advance the model, then check the registered read outputs.
  task automatic cycle(input logic wv, input logic [NB-1:0] wi, input logic [L-1:0] fl,
                       input logic [(NSAT-1)*L-1:0] tl, input logic [BW-1:0] bc,
                       input logic cm, input logic rq, input logic [NB-1:0] ri,
                       input logic rl, input logic fs);
    gen_t f;
    logic ready, avail, exp_cv, exp_miss;
    int   s;
    flush_i                 = fs;
    wr_valid_i              = wv;
    write_index_i           = wi;
    flipped_literal_i       = fl;
    clause_table_literals_i = tl;
    break_count_i           = bc;
    wr_commit_i             = cm;
    rd_req_i                = rq;
    read_index_i            = ri;
    rd_release_i            = rl;
    #1;
    ready = (q.size() < 2);
    avail = (q.size() != 0);
    f     = avail ? q[0] : '0;
    check("wr_ready",     64'(wr_ready_o),     64'(ready));
    check("rd_avail",     64'(rd_avail_o),     64'(avail));
    check("row_valid",    64'(row_valid_o),    64'(f.valid));
    check("break_counts", 64'(break_counts_o), 64'(f.count));

    exp_cv   = 1'b0;
    exp_miss = 1'b0;
    if (fs) begin
      model_reset();
    end else begin
      if (rq && avail) begin
        exp_cv = 1'b1;
        if (int'(ri) < NSAT && f.valid[ri]) begin
          m_clause = f.lits[ri];
        end else begin
          m_clause = '0;
          exp_miss = 1'b1;
        end
      end
      if (rl && avail) void'(q.pop_front());
      if (wv && ready && int'(wi) < NSAT) begin
        cur.valid[wi] = 1'b1;
        cur.lits[wi]  = {tl, fl};
        s = int'(cur.count[wi]) + int'(bc);
        if (s > 255) s = 255;
        cur.count[wi] = BW'(s);
      end
      if (cm && ready) begin
        q.push_back(cur);
        cur = '0;
      end
    end

    @(posedge clk);
    #1;
    check("clause_valid", 64'(clause_valid_o), 64'(exp_cv));
    if (exp_cv) check("miss", 64'(miss_o), 64'(exp_miss));
    check("clause", 64'(clause_o), 64'(m_clause));
    idle_inputs();
  endtask

  task automatic wr(input logic [NB-1:0] wi, input logic [BW-1:0] bc, input logic cm);
    cycle(1'b1, wi, L'(12'h100 + wi), 24'($urandom), bc, cm, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [NB-1:0] ri, input logic rl);
    cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, ri, rl, 1'b0);
  endtask

  task automatic nop();
    cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b0;
    #12;
    check("rst_wr_ready",     64'(wr_ready_o),     64'(1));
    check("rst_rd_avail",     64'(rd_avail_o),     64'(0));
    check("rst_row_valid",    64'(row_valid_o),    64'(0));
    check("rst_break_counts", 64'(break_counts_o), 64'(0));
    check("rst_clause",       64'(clause_o),       64'(0));
    check("rst_clause_valid", 64'(clause_valid_o), 64'(0));
    check("rst_miss",         64'(miss_o),         64'(0));
    @(negedge clk);
    reset = 1'b1;

    // Fill rows 0..2 with counts 1,2,3; the last write shares the commit cycle.
    wr(2'd0, 8'd1, 1'b0);
    wr(2'd1, 8'd2, 1'b0);
    wr(2'd2, 8'd3, 1'b1);
    check("gen0_counts", 64'(break_counts_o), 64'(24'h030201));
    check("gen0_valid",  64'(row_valid_o),    64'(3'b111));

    // Clause read, then out-of-range read (back to back).
    rd(2'd1, 1'b0);
    rd(2'd3, 1'b0);
    rd(2'd0, 1'b0);

    // Second generation: row 0 twice with 200 -> saturates at 255.
    wr(2'd0, 8'd200, 1'b0);
    wr(2'd0, 8'd200, 1'b1);
    check("both_full_ready", 64'(wr_ready_o), 64'(0));
    // Offered write and commit while both banks are full are ignored.
    wr(2'd1, 8'd7, 1'b1);
    rd(2'd2, 1'b1);       // read with release: pre-release clause
    check("gen1_counts", 64'(break_counts_o), 64'(24'h0000FF));
    check("gen1_valid",  64'(row_valid_o),    64'(3'b001));
    rd(2'd1, 1'b0);       // unwritten row -> miss
    rd(2'd0, 1'b0);

    // Third generation written; then same-cycle commit, release and read.
    wr(2'd2, 8'd9, 1'b0);
    cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    nop();
    rd(2'd2, 1'b0);

    // Reset asserted while a read is in flight: no clause_valid pulse.
    rd_req_i     = 1'b1;
    read_index_i = 2'd2;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_clause_valid", 64'(clause_valid_o), 64'(0));
    check("mid_rst_clause",       64'(clause_o),       64'(0));
    check("mid_rst_rd_avail",     64'(rd_avail_o),     64'(0));
    check("mid_rst_wr_ready",     64'(wr_ready_o),     64'(1));
    check("mid_rst_counts",       64'(break_counts_o), 64'(0));
    @(posedge clk);
    #1;
    check("mid_rst_no_pulse", 64'(clause_valid_o), 64'(0));
    check("mid_rst_miss",     64'(miss_o),         64'(0));
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [BW-1:0] bc;
      bc = ($urandom_range(0, 3) == 0) ? BW'($urandom_range(128, 255)) : BW'($urandom_range(0, 20));
      cycle(($urandom_range(0, 9) < 7),
            NB'($urandom_range(0, 3)),
            L'($urandom),
            24'($urandom),
            bc,
            ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 1) == 1),
            NB'($urandom_range(0, 3)),
            ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
